button_debounce_multi: RTL and testbench
========================================

Name: button_debounce_multi

Overview:
- N-channel push-button conditioner for the FPGA DSP board front panel. Used for filter/waveform selection and gain up/down.
- Each channel does three things:
  - synchronises the raw pad input;
  - debounces it with a cycle counter;
  - runs a press-tracking FSM that emits one-cycle press, release, long-press and auto-repeat pulses.
- Feeds control/menu logic directly. All outputs are registered and in the i_clk domain.

Parameters:
- N_BTN, 4: number of independent button channels.
- DEBOUNCE_CYC, 500000: consecutive cycles the synchronised input must differ from the debounced level before the level flips. Must be >= 1.
- HOLD_CYC, 50000000: cycles after the press pulse at which the long-press pulse fires. Must be >= 1.
- REPEAT_CYC, 10000000: auto-repeat period after long press. 0 disables repeat.
- ACTIVE_LOW, 1: 1 means a pad level of 0 is "pressed". The input is inverted before the synchroniser.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_button  in  N_BTN  raw asynchronous pad inputs.
- o_level  out  N_BTN  debounced pressed level (1 = pressed).
- o_press  out  N_BTN  1-cycle pulse on accepted press.
- o_release  out  N_BTN  1-cycle pulse on accepted release.
- o_long  out  N_BTN  1-cycle pulse when press has lasted HOLD_CYC.
- o_repeat  out  N_BTN  1-cycle auto-repeat pulses during long hold.
- o_any_press  out  1  OR of o_press, registered in the same cycle.

Behaviour:
- Reset (i_rst=0 at a posedge i_clk) applies to every channel:
  - sync FFs, debounced level and all counters go to 0 (logical not-pressed);
  - FSM goes to IDLE;
  - every output is 0.
- Reset mid-press produces no release pulse. After reset a held button must be re-debounced and then yields a fresh o_press.
- Input path: the raw bit is inverted when ACTIVE_LOW=1, then passes through a 2-FF synchroniser giving s.
- Debounce counter:
  - When s != level, dcnt increments.
  - When s == level, dcnt clears to 0.
  - When s != level and dcnt == DEBOUNCE_CYC-1, level toggles and dcnt clears.
  - Any single-cycle return of s to level restarts the count.
  - Width is $clog2(DEBOUNCE_CYC+1). The counter never wraps.
- Latency: a raw change held stable is reflected on o_level exactly 2+DEBOUNCE_CYC cycles after the first posedge that samples it.
- Channel FSM (shared enum, 2 bits):
  - IDLE: on a level rising edge, go to PRESS, o_press=1, hcnt=0.
  - PRESS: hcnt increments each cycle. When hcnt == HOLD_CYC-1, go to LONG, o_long=1, rcnt=0. On a level falling edge, go to IDLE, o_release=1.
  - LONG: when REPEAT_CYC != 0, rcnt increments. When rcnt == REPEAT_CYC-1, o_repeat=1 and rcnt=0. On a level falling edge, go to IDLE, o_release=1.
  - Default: IDLE.
- Pulse timing:
  - o_press and the rising edge of o_level occur in the same cycle.
  - o_long occurs exactly HOLD_CYC cycles after o_press.
  - The k-th o_repeat occurs k*REPEAT_CYC cycles after o_long.
- Simultaneous events: release has priority. If a falling edge of level coincides with the cycle hcnt or rcnt would fire, only o_release pulses.
- At most one of o_press, o_release, o_long, o_repeat is high per channel per cycle.
- hcnt and rcnt saturate and never wrap. Their widths are $clog2(HOLD_CYC+1) and $clog2(REPEAT_CYC+1), minimum 1.
- Channels are fully independent. The same-cycle presses on several channels each pulse, and o_any_press=1 for that cycle.

Decomposition:
- Package button_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRESS, LONG} btn_state_e;
  - localparam function clog2-based width helper.
- Sub-module button_channel implements one channel: synchroniser, debounce counter, FSM and counters, with the same parameters minus N_BTN.
- Top level is a generate loop over N_BTN plus the o_any_press OR register.

Test Plan:
All scenarios use N_BTN=2, ACTIVE_LOW=1, DEBOUNCE_CYC=4, HOLD_CYC=10, REPEAT_CYC=5.
- Reset:
  - Stimulus: hold i_rst=0 for 3 cycles with i_button=2'b00 (both pressed).
  - Response: all outputs 0 during reset. o_press[1:0]=2'b11 and o_any_press=1 exactly 6 cycles after i_rst rises.
- Bounce rejection:
  - Stimulus: ch0 toggles 0/1 every 2 cycles for 20 cycles, then ends at 1 (released).
  - Response: no o_press[0], o_level[0] stays 0.
- Clean press/release:
  - Stimulus: i_button[0] goes to 0 at cycle T, held 8 cycles, then back to 1.
  - Response: o_press[0] at T+6, o_release[0] at T+14, no o_long.
- Long press with repeat:
  - Stimulus: i_button[0]=0 held 40 cycles from T.
  - Response: o_press at T+6, o_long at T+16, o_repeat at T+21, T+26, T+31, T+36, T+41. o_release 6 cycles after the input returns high.
- Release/long collision:
  - Stimulus: release timed so the level falls at o_press+10.
  - Response: o_release only, no o_long.
- Reset mid-hold:
  - Stimulus: drive i_rst=0 during LONG.
  - Response: no o_release. After reset, o_press fires again at deassert+6.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the front-panel button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } btn_state_e;

    // Width of a counter that must hold 0..max_val, never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = (max_val < 1) ? 1 : $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: pad synchroniser, debounce counter and press-tracking FSM
// producing one-cycle press/release/long/repeat pulses.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_press_next
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYC);
    localparam int HOLD_W = cnt_width(HOLD_CYC);
    localparam int RPT_W  = cnt_width(REPEAT_CYC);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'((REPEAT_CYC == 0) ? 0 : REPEAT_CYC - 1);

    logic              pad_pressed;
    logic              sync1_q;
    logic              sync2_q;
    logic              level_q;
    logic              level_d;
    logic [DB_W-1:0]   dcnt_q;
    logic [DB_W-1:0]   dcnt_d;
    btn_state_e        state_q;
    logic [HOLD_W-1:0] hcnt_q;
    logic [RPT_W-1:0]  rcnt_q;
    logic              level_out_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              repeat_q;
    logic              rise_w;
    logic              fall_w;
    logic              press_d;

    assign pad_pressed = ACTIVE_LOW ? ~i_button : i_button;

    // Any cycle where s agrees with the level restarts the count.
    always_comb begin
        dcnt_d  = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (dcnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            sync1_q <= pad_pressed;
            sync2_q <= sync1_q;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Edges are taken against the registered output copy so o_press lines up with o_level.
    assign rise_w  = level_q & ~level_out_q;
    assign fall_w  = ~level_q & level_out_q;
    assign press_d = (state_q == IDLE) & rise_w;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            rcnt_q      <= '0;
            level_out_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            level_out_q <= level_q;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_d) begin
                        state_q <= PRESS;
                        press_q <= 1'b1;
                        hcnt_q  <= '0;
                    end
                end
                PRESS: begin
                    if (fall_w) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                    end else if (hcnt_q == HOLD_LAST) begin
                        state_q <= LONG;
                        long_q  <= 1'b1;
                        rcnt_q  <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                LONG: begin
                    if (fall_w) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                    end else if (REPEAT_CYC != 0) begin
                        if (rcnt_q == RPT_LAST) begin
                            repeat_q <= 1'b1;
                            rcnt_q   <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_level      = level_out_q;
    assign o_press      = press_q;
    assign o_release    = release_q;
    assign o_long       = long_q;
    assign o_repeat     = repeat_q;
    assign o_press_next = press_d;

endmodule

// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner: independent debounce/press channels plus
// a registered any-press flag aligned with the per-channel press pulses.
module button_debounce_multi
    import button_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_button,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long,
    output logic [N_BTN-1:0] o_repeat,
    output logic             o_any_press
);

    logic [N_BTN-1:0] press_next_w;
    logic             any_press_q;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            button_channel #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC),
                .HOLD_CYC    (HOLD_CYC),
                .REPEAT_CYC  (REPEAT_CYC),
                .ACTIVE_LOW  (ACTIVE_LOW)
            ) u_ch (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_button    (i_button[gi]),
                .o_level     (o_level[gi]),
                .o_press     (o_press[gi]),
                .o_release   (o_release[gi]),
                .o_long      (o_long[gi]),
                .o_repeat    (o_repeat[gi]),
                .o_press_next(press_next_w[gi])
            );
        end
    endgenerate

    // Built from each channel's next-press term so it rises with o_press, not after it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_next_w;
        end
    end

    assign o_any_press = any_press_q;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi: table of press durations with
// hand-computed pulse timings, plus reset and bounce sequences.
module tb_button_debounce_multi;

    localparam int N_BTN = 2;
    localparam int DEB   = 4;
    localparam int HOLD  = 10;
    localparam int RPT   = 5;
    localparam int NVEC  = 7;

    localparam logic [3:0] EV_P  = 4'b0001;
    localparam logic [3:0] EV_R  = 4'b0010;
    localparam logic [3:0] EV_L  = 4'b0100;
    localparam logic [3:0] EV_RP = 4'b1000;

    typedef struct packed {
        logic [7:0]      hold;
        logic [3:0]      n_ev;
        logic [7:0][7:0] ev_at;
        logic [7:0][3:0] ev_bits;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] o_level;
    logic [N_BTN-1:0] o_press;
    logic [N_BTN-1:0] o_release;
    logic [N_BTN-1:0] o_long;
    logic [N_BTN-1:0] o_repeat;
    logic             o_any_press;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    button_debounce_multi #(
        .N_BTN       (N_BTN),
        .DEBOUNCE_CYC(DEB),
        .HOLD_CYC    (HOLD),
        .REPEAT_CYC  (RPT),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_button   (btn),
        .o_level    (o_level),
        .o_press    (o_press),
        .o_release  (o_release),
        .o_long     (o_long),
        .o_repeat   (o_repeat),
        .o_any_press(o_any_press)
    );

    task automatic check(input string name, input int k, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s k=%0d got=%b exp=%b", name, k, got, exp);
        end
    endtask

    task automatic add_ev(input int v, input int at, input logic [3:0] b);
        logic [2:0] idx;
        idx = vecs[v].n_ev[2:0];
        vecs[v].ev_at[idx]   = 8'(at);
        vecs[v].ev_bits[idx] = b;
        vecs[v].n_ev         = vecs[v].n_ev + 4'd1;
    endtask

    function automatic logic [15:0] all_outs();
        return 16'({o_level, o_press, o_release, o_long, o_repeat, o_any_press});
    endfunction

    initial begin
        // Offsets are counted from the first posedge that samples the press.
        for (int v = 0; v < NVEC; v++) vecs[v] = '0;
        vecs[0].hold = 8'd8;  add_ev(0, 6, EV_P); add_ev(0, 14, EV_R);
        vecs[1].hold = 8'd40; add_ev(1, 6, EV_P); add_ev(1, 16, EV_L);
        add_ev(1, 21, EV_RP); add_ev(1, 26, EV_RP); add_ev(1, 31, EV_RP);
        add_ev(1, 36, EV_RP); add_ev(1, 41, EV_RP); add_ev(1, 46, EV_R);
        vecs[2].hold = 8'd10; add_ev(2, 6, EV_P); add_ev(2, 16, EV_R);
        vecs[3].hold = 8'd9;  add_ev(3, 6, EV_P); add_ev(3, 15, EV_R);
        vecs[4].hold = 8'd15; add_ev(4, 6, EV_P); add_ev(4, 16, EV_L); add_ev(4, 21, EV_R);
        vecs[5].hold = 8'd4;  add_ev(5, 6, EV_P); add_ev(5, 10, EV_R);
        vecs[6].hold = 8'd3;

        // Reset with both buttons held, then both must be re-debounced.
        rst = 1'b0;
        btn = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            check("reset_outputs", k, all_outs(), 16'd0);
        end
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [10:0] got, exp;
            @(posedge clk); @(negedge clk);
            got = {o_any_press, o_level, o_press, o_release, o_long, o_repeat};
            exp = '0;
            exp[10]  = (k == 6);
            exp[9:8] = (k >= 6) ? 2'b11 : 2'b00;
            exp[7:6] = (k == 6) ? 2'b11 : 2'b00;
            check("post_reset_press", k, 16'(got), 16'(exp));
        end
        btn = 2'b11;
        repeat (15) @(negedge clk);

        // Bounce: 2-cycle pulses never reach the 4-cycle debounce count.
        begin
            int seen_press, seen_level;
            seen_press = 0;
            seen_level = 0;
            for (int c = 0; c < 30; c++) begin
                if (c < 20) btn[0] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
                @(posedge clk); @(negedge clk);
                if (o_press[0] || o_any_press) seen_press++;
                if (o_level[0]) seen_level++;
            end
            check("bounce_press", 0, 16'(seen_press), 16'd0);
            check("bounce_level", 0, 16'(seen_level), 16'd0);
        end

        // Table of press durations on ch0; ch1 stays released.
        for (int v = 0; v < NVEC; v++) begin
            int h, w, quiet;
            logic [5:0] exp, got;
            h = int'(vecs[v].hold);
            w = h + 12;
            quiet = 0;
            @(negedge clk);
            btn[0] = 1'b0;
            for (int k = 0; k < w; k++) begin
                @(posedge clk); @(negedge clk);
                exp = '0;
                for (int e = 0; e < 8; e++) begin
                    if (e < int'(vecs[v].n_ev) && int'(vecs[v].ev_at[e]) == k)
                        exp[3:0] = exp[3:0] | vecs[v].ev_bits[e];
                end
                exp[4] = (h >= DEB) && (k >= DEB + 2) && (k < h + DEB + 2);
                exp[5] = exp[0];
                got = {o_any_press, o_level[0], o_repeat[0], o_long[0], o_release[0], o_press[0]};
                check($sformatf("hold%0d_ch0", h), k, 16'(got), 16'(exp));
                if ({o_level[1], o_press[1], o_release[1], o_long[1], o_repeat[1]} != 5'd0) quiet++;
                if (k == h - 1) btn[0] = 1'b1;
            end
            check("ch1_quiet", v, 16'(quiet), 16'd0);
        end

        // Reset while in LONG: no release, then a fresh press once re-debounced.
        @(negedge clk);
        btn[0] = 1'b0;
        repeat (22) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk);
            check("midhold_reset", k, all_outs(), 16'd0);
        end
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic [5:0] exp, got;
            @(posedge clk); @(negedge clk);
            exp = {(k == 6), (k >= 6), 1'b0, 1'b0, 1'b0, (k == 6)};
            got = {o_any_press, o_level[0], o_repeat[0], o_long[0], o_release[0], o_press[0]};
            check("midhold_repress", k, 16'(got), 16'(exp));
        end
        btn = 2'b11;
        repeat (15) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
